// File: rtl/parity_checker.sv
// Reduction-XOR parity of one data word: o_parity is 1 when the word holds an odd number of ones.
module parity_checker #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_parity
);

    assign o_parity = ^i_data;

endmodule

// File: rtl/parity_stream_checker.sv
// Multi-lane parity checker on a valid/ready stream behind a one-deep register slice,
// with sticky per-lane flags, a saturating erroneous-beat counter and first-error capture.
module parity_stream_checker #(
    parameter int unsigned  DATA_WIDTH       = 32,
    parameter int unsigned  LANE_WIDTH       = 8,
    parameter bit           ODD_PARITY       = 1'b0,
    parameter int unsigned  COUNTER_WIDTH    = 8,
    localparam int unsigned LANES            = DATA_WIDTH / LANE_WIDTH,
    localparam int unsigned LANE_INDEX_WIDTH = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        upstream_valid,
    output logic                        upstream_ready,
    input  logic [DATA_WIDTH-1:0]       upstream_data,
    input  logic [LANES-1:0]            upstream_code,
    output logic                        downstream_valid,
    input  logic                        downstream_ready,
    output logic [DATA_WIDTH-1:0]       downstream_data,
    output logic [LANES-1:0]            downstream_error,
    input  logic                        clear,
    output logic [LANES-1:0]            error_sticky,
    output logic [COUNTER_WIDTH-1:0]    error_count,
    output logic                        first_error_valid,
    output logic [LANE_INDEX_WIDTH-1:0] first_error_lane
);

    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane_width
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (COUNTER_WIDTH < 1) begin : g_bad_counter_width
        $error("COUNTER_WIDTH must be at least 1");
    end

    // Lowest set bit wins: scan downwards so the last hit is the smallest index.
    function automatic logic [LANE_INDEX_WIDTH-1:0] lowest_lane(input logic [LANES-1:0] vec);
        lowest_lane = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_lane = LANE_INDEX_WIDTH'(i);
            end
        end
    endfunction

    logic [LANES-1:0]            w_lane_parity;
    logic [LANES-1:0]            w_err;
    logic                        w_any_err;
    logic                        w_accept;

    logic                        r_dn_valid;
    logic [DATA_WIDTH-1:0]       r_dn_data;
    logic [LANES-1:0]            r_dn_error;

    logic [LANES-1:0]            r_sticky;
    logic [COUNTER_WIDTH-1:0]    r_count;
    logic                        r_first_valid;
    logic [LANE_INDEX_WIDTH-1:0] r_first_lane;

    logic [LANES-1:0]            w_sticky_nxt;
    logic [COUNTER_WIDTH-1:0]    w_count_nxt;
    logic                        w_first_valid_nxt;
    logic [LANE_INDEX_WIDTH-1:0] w_first_lane_nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parity_checker #(
            .DATA_WIDTH(LANE_WIDTH)
        ) u_parity (
            .i_data  (upstream_data[i*LANE_WIDTH +: LANE_WIDTH]),
            .o_parity(w_lane_parity[i])
        );
    end

    assign w_err     = w_lane_parity ^ upstream_code ^ {LANES{ODD_PARITY}};
    assign w_any_err = |w_err;

    assign upstream_ready = !r_dn_valid || downstream_ready;
    assign w_accept       = upstream_valid && upstream_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dn_valid <= 1'b0;
            r_dn_data  <= '0;
            r_dn_error <= '0;
        end else if (w_accept) begin
            r_dn_valid <= 1'b1;
            r_dn_data  <= upstream_data;
            r_dn_error <= w_err;
        end else if (downstream_ready) begin
            r_dn_valid <= 1'b0;
        end
    end

    // clear is applied first so an erroneous beat accepted in the same cycle survives it.
    always_comb begin
        w_sticky_nxt      = r_sticky;
        w_count_nxt       = r_count;
        w_first_valid_nxt = r_first_valid;
        w_first_lane_nxt  = r_first_lane;
        if (clear) begin
            w_sticky_nxt      = '0;
            w_count_nxt       = '0;
            w_first_valid_nxt = 1'b0;
            w_first_lane_nxt  = '0;
        end
        if (w_accept && w_any_err) begin
            w_sticky_nxt = w_sticky_nxt | w_err;
            if (w_count_nxt != COUNT_MAX) begin
                w_count_nxt = w_count_nxt + COUNTER_WIDTH'(1);
            end
            if (!w_first_valid_nxt) begin
                w_first_valid_nxt = 1'b1;
                w_first_lane_nxt  = lowest_lane(w_err);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sticky      <= '0;
            r_count       <= '0;
            r_first_valid <= 1'b0;
            r_first_lane  <= '0;
        end else begin
            r_sticky      <= w_sticky_nxt;
            r_count       <= w_count_nxt;
            r_first_valid <= w_first_valid_nxt;
            r_first_lane  <= w_first_lane_nxt;
        end
    end

    assign downstream_valid  = r_dn_valid;
    assign downstream_data   = r_dn_data;
    assign downstream_error  = r_dn_error;
    assign error_sticky      = r_sticky;
    assign error_count       = r_count;
    assign first_error_valid = r_first_valid;
    assign first_error_lane  = r_first_lane;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Drives an even-parity/8-bit-counter and an odd-parity/2-bit-counter checker with the same
// stream and compares both against a lane-arithmetic model of the stream and status rules.
module tb_parity_stream_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_valid;
    logic [31:0] up_data;
    logic [3:0]  up_code;
    logic        dn_ready;
    logic        clr;

    logic        up_ready [2];
    logic        dn_valid [2];
    logic [31:0] dn_data  [2];
    logic [3:0]  dn_err   [2];
    logic [3:0]  sticky   [2];
    logic        fev      [2];
    logic [1:0]  fel      [2];
    logic [7:0]  cnt_even;
    logic [1:0]  cnt_odd;
    logic [7:0]  cnt      [2];

    assign cnt[0] = cnt_even;
    assign cnt[1] = {6'd0, cnt_odd};

    always #5 clk = ~clk;

    parity_stream_checker #(
        .DATA_WIDTH(32), .LANE_WIDTH(8), .ODD_PARITY(1'b0), .COUNTER_WIDTH(8)
    ) u_dut_even (
        .clock(clk), .reset(rst),
        .upstream_valid(up_valid), .upstream_ready(up_ready[0]),
        .upstream_data(up_data), .upstream_code(up_code),
        .downstream_valid(dn_valid[0]), .downstream_ready(dn_ready),
        .downstream_data(dn_data[0]), .downstream_error(dn_err[0]),
        .clear(clr), .error_sticky(sticky[0]), .error_count(cnt_even),
        .first_error_valid(fev[0]), .first_error_lane(fel[0])
    );

    parity_stream_checker #(
        .DATA_WIDTH(32), .LANE_WIDTH(8), .ODD_PARITY(1'b1), .COUNTER_WIDTH(2)
    ) u_dut_odd (
        .clock(clk), .reset(rst),
        .upstream_valid(up_valid), .upstream_ready(up_ready[1]),
        .upstream_data(up_data), .upstream_code(up_code),
        .downstream_valid(dn_valid[1]), .downstream_ready(dn_ready),
        .downstream_data(dn_data[1]), .downstream_error(dn_err[1]),
        .clear(clr), .error_sticky(sticky[1]), .error_count(cnt_odd),
        .first_error_valid(fev[1]), .first_error_lane(fel[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference state: the single beat waiting downstream plus the status it should report.
    bit          m_odd  [2] = '{1'b0, 1'b1};
    int          m_max  [2] = '{255, 3};
    bit          m_full [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_err  [2];
    logic [3:0]  m_sticky [2];
    int          m_count  [2];
    bit          m_fev    [2];
    int          m_fel    [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // A lane is in error when lane bits plus its code bit have the wrong number of ones.
    function automatic logic [3:0] exp_err(input logic [31:0] d, input logic [3:0] c,
                                           input bit odd);
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            int ones;
            ones = $countones(d[i*8 +: 8]) + int'(c[i]);
            e[i] = ((ones % 2) == 1) != odd;
        end
        return e;
    endfunction

    function automatic logic [3:0] good_code(input logic [31:0] d, input bit odd);
        logic [3:0] c;
        for (int i = 0; i < 4; i++) c[i] = ($countones(d[i*8 +: 8]) % 2 == 1) ^ odd;
        return c;
    endfunction

    function automatic int lowest(input logic [3:0] e);
        for (int i = 0; i < 4; i++) if (e[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 0; m_data[k] = '0; m_err[k] = '0;
            m_sticky[k] = '0; m_count[k] = 0; m_fev[k] = 0; m_fel[k] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("dn_valid", k, dn_valid[k], m_full[k]);
            if (m_full[k]) begin
                chk("dn_data", k, dn_data[k], m_data[k]);
                chk("dn_error", k, dn_err[k], m_err[k]);
            end
            chk("sticky", k, sticky[k], m_sticky[k]);
            chk("count", k, cnt[k], m_count[k]);
            chk("first_valid", k, fev[k], m_fev[k]);
            chk("first_lane", k, fel[k], m_fel[k]);
        end
    endtask

    // One clock: drive inputs, check ready, take the edge, update the model, check outputs.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] c,
                        input logic dr, input logic cl);
        up_valid = v; up_data = d; up_code = c; dn_ready = dr; clr = cl;
        #1;
        for (int k = 0; k < 2; k++) chk("up_ready", k, up_ready[k], !m_full[k] || dr);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit         acc;
            logic [3:0] e;
            acc = v && (!m_full[k] || dr);
            e   = exp_err(d, c, m_odd[k]);
            if (m_full[k] && dr) m_full[k] = 0;
            if (acc) begin
                m_full[k] = 1; m_data[k] = d; m_err[k] = e;
            end
            if (cl) begin
                m_sticky[k] = '0; m_count[k] = 0; m_fev[k] = 0; m_fel[k] = 0;
            end
            if (acc && e != 4'b0000) begin
                m_sticky[k] |= e;
                if (m_count[k] < m_max[k]) m_count[k]++;
                if (!m_fev[k]) begin
                    m_fev[k] = 1; m_fel[k] = lowest(e);
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic reset_mid_cycle();
        #2;
        rst = 1'b1; up_valid = 1'b0; clr = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_dn_valid", k, dn_valid[k], 0);
            chk("rst_dn_data", k, dn_data[k], 0);
            chk("rst_dn_error", k, dn_err[k], 0);
            chk("rst_sticky", k, sticky[k], 0);
            chk("rst_count", k, cnt[k], 0);
            chk("rst_first", k, {fev[k], fel[k]}, 0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    int sat_seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        logic [31:0] d;
        logic [3:0]  inj;
        rst = 1'b1; up_valid = 1'b0; up_data = '0; up_code = '0; dn_ready = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        // Clean beat: lanes 0x78,0x56,0x34,0x12 have 4,4,3,2 ones -> even code 4'b0100.
        step(1'b1, 32'h1234_5678, 4'b0100, 1'b1, 1'b0);
        chk("t1_valid", 0, dn_valid[0], 1);
        chk("t1_data", 0, dn_data[0], 32'h1234_5678);
        chk("t1_error", 0, dn_err[0], 0);
        chk("t1_count", 0, cnt[0], 0);
        step(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

        // Backpressure: two beats offered while the sink stalls for three cycles.
        step(1'b1, 32'hA5A5_0F0F, good_code(32'hA5A5_0F0F, 1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h1357_9BDF, good_code(32'h1357_9BDF, 1'b0), 1'b0, 1'b0);
            chk("t2_hold", 0, dn_data[0], 32'hA5A5_0F0F);
        end
        step(1'b1, 32'h1357_9BDF, good_code(32'h1357_9BDF, 1'b0), 1'b1, 1'b0);
        chk("t2_second", 0, dn_data[0], 32'h1357_9BDF);
        for (int i = 0; i < 4; i++) begin
            d = 32'h0101_0101 * (i + 3);
            step(1'b1, d, good_code(d, 1'b0), 1'b1, 1'b0);
        end
        step(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);

        // Single-lane error, then lanes 3 and 0.
        step(1'b1, 32'h0000_0100, 4'b0000, 1'b1, 1'b0);
        chk("t3_error", 0, dn_err[0], 4'b0010);
        chk("t3_sticky", 0, sticky[0], 4'b0010);
        chk("t3_count", 0, cnt[0], 1);
        chk("t3_first", 0, {fev[0], fel[0]}, 3'b101);
        step(1'b1, 32'h0100_0001, 4'b0000, 1'b1, 1'b0);
        chk("t3_sticky2", 0, sticky[0], 4'b1011);
        chk("t3_count2", 0, cnt[0], 2);
        chk("t3_lane2", 0, fel[0], 1);

        // Saturation of the 2-bit counter; code 4'b0001 on zero data is wrong for both parities.
        step(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0, 4'b0001, 1'b1, 1'b0);
            chk("t4_sat", 1, cnt[1], sat_seq[i]);
        end
        step(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);
        step(1'b1, 32'h0, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 4'b0001, 1'b0, 1'b0);
        chk("t4_held", 0, cnt[0], 1);
        step(1'b1, 32'h0, 4'b0001, 1'b1, 1'b0);
        chk("t4_once", 0, cnt[0], 2);
        step(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

        // clear alone, then clear racing an erroneous accept on lane 2.
        step(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);
        chk("t5_clear", 0, {sticky[0], cnt[0], fev[0], fel[0]}, 0);
        step(1'b1, 32'h0000_0100, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 32'h0001_0000, 4'b0000, 1'b1, 1'b1);
        chk("t5_sticky", 0, sticky[0], 4'b0100);
        chk("t5_count", 0, cnt[0], 1);
        chk("t5_lane", 0, fel[0], 2);

        // Random stream coded for odd parity with occasional injected lane errors.
        for (int i = 0; i < 10000; i++) begin
            d   = $urandom;
            inj = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if (i == 5000) begin
                step(1'b1, d, good_code(d, 1'b1) ^ inj, 1'b0, 1'b0);
                reset_mid_cycle();
            end else begin
                step($urandom_range(0, 3) != 0, d, good_code(d, 1'b1) ^ inj,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
